// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: instruction field positions, opcode constants,
// the decoded-entry record held by the splitter buffer and its occupancy states.
package mips_pkg;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int TGT_MSB   = 25;
  localparam int TGT_LSB   = 0;

  localparam logic [5:0] OPC_RTYPE = 6'h00;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic        is_rtype;
    logic [31:0] imm_ext;
    logic [31:0] branch_off;
    logic [31:0] jump_addr;
  } dec_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of one instruction word into its decoded entry.
// Build option IMM_SIGN_EXT_EN selects sign (defined) or zero (default) immediate extension.
module instr_field_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [3:0]  pc_hi,
  output dec_entry_t  dec
);

  logic [31:0] imm_ext;

`ifdef IMM_SIGN_EXT_EN
  logic signed [15:0] imm_s;
  logic signed [31:0] imm_sext;

  assign imm_s    = $signed(instr[IMM_MSB:IMM_LSB]);
  assign imm_sext = imm_s;
  assign imm_ext  = imm_sext;
`else
  assign imm_ext  = {16'b0, instr[IMM_MSB:IMM_LSB]};
`endif

  always_comb begin
    dec            = '0;
    dec.opcode     = instr[OPC_MSB:OPC_LSB];
    dec.rs         = instr[RS_MSB:RS_LSB];
    dec.rt         = instr[RT_MSB:RT_LSB];
    dec.rd         = instr[RD_MSB:RD_LSB];
    dec.shamt      = instr[SHAMT_MSB:SHAMT_LSB];
    dec.funct      = instr[FUNCT_MSB:FUNCT_LSB];
    dec.is_rtype   = (instr[OPC_MSB:OPC_LSB] == OPC_RTYPE);
    dec.imm_ext    = imm_ext;
    dec.branch_off = {imm_ext[29:0], 2'b00};
    // Jump target keeps the region bits of the delay-slot PC.
    dec.jump_addr  = {pc_hi, instr[TGT_MSB:TGT_LSB], 2'b00};
  end

endmodule

// File: rtl/instr_field_splitter.sv
// Registered instruction decode buffer with a two-entry skid (HEAD/SKID), valid/ready
// on both sides, flush, and a saturating accept counter. Option macro: IMM_SIGN_EXT_EN.
module instr_field_splitter
  import mips_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  input  logic [31:0]        pc_plus4,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         funct,
  output logic               is_rtype,
  output logic [31:0]        imm_ext,
  output logic [31:0]        branch_off,
  output logic [31:0]        jump_addr,
  output logic [COUNT_W-1:0] instr_count
);

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  buf_state_t         state_q;
  buf_state_t         state_nxt;
  logic               in_ready_q;
  logic [COUNT_W-1:0] count_q;
  dec_entry_t         dec_p0;
  dec_entry_t         head_p1;
  dec_entry_t         skid_p1;
  logic               accept;
  logic               pop;
  logic               ld_head;
  logic               ld_skid;
  logic               shift;
  logic               unused_pc_lo;

  assign unused_pc_lo = ^pc_plus4[27:0];

  instr_field_decode u_decode (
    .instr (instr),
    .pc_hi (pc_plus4[31:28]),
    .dec   (dec_p0)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_nxt = state_q;
    ld_head   = 1'b0;
    ld_skid   = 1'b0;
    shift     = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_ONE;
          ld_head   = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          ld_head = 1'b1;
        end else if (accept) begin
          state_nxt = ST_TWO;
          ld_skid   = 1'b1;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_nxt = ST_ONE;
          shift     = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush wins over any same-cycle transfer; nothing is captured or moved.
    if (flush) begin
      state_nxt = ST_EMPTY;
      ld_head   = 1'b0;
      ld_skid   = 1'b0;
      shift     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_nxt;
      in_ready_q <= (state_nxt != ST_TWO);
      if (accept) begin
        count_q <= sat_inc(count_q);
      end
    end
  end

  // p0 -> p1: decoded word is captured into HEAD or SKID; SKID advances into HEAD on pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      if (ld_head) begin
        head_p1 <= dec_p0;
      end else if (shift) begin
        head_p1 <= skid_p1;
      end
      if (ld_skid) begin
        skid_p1 <= dec_p0;
      end
    end
  end

  assign opcode      = head_p1.opcode;
  assign rs          = head_p1.rs;
  assign rt          = head_p1.rt;
  assign rd          = head_p1.rd;
  assign shamt       = head_p1.shamt;
  assign funct       = head_p1.funct;
  assign is_rtype    = head_p1.is_rtype;
  assign imm_ext     = head_p1.imm_ext;
  assign branch_off  = head_p1.branch_off;
  assign jump_addr   = head_p1.jump_addr;
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_field_splitter.sv
// Self-checking bench for instr_field_splitter: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_instr_field_splitter;

  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   instr;
  logic [31:0]   pc_plus4;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [5:0]    opcode;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [4:0]    shamt;
  logic [5:0]    funct;
  logic          is_rtype;
  logic [31:0]   imm_ext;
  logic [31:0]   branch_off;
  logic [31:0]   jump_addr;
  logic [CW-1:0] instr_count;

  instr_field_splitter #(.COUNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .pc_plus4    (pc_plus4),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .funct       (funct),
    .is_rtype    (is_rtype),
    .imm_ext     (imm_ext),
    .branch_off  (branch_off),
    .jump_addr   (jump_addr),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] opcode;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] rd;
    logic [31:0] shamt;
    logic [31:0] funct;
    logic [31:0] is_rtype;
    logic [31:0] imm_ext;
    logic [31:0] branch_off;
    logic [31:0] jump_addr;
  } exp_t;

  exp_t q[$];
  int   m_count;
  bit   m_ready;
  int   n_checks;
  int   n_fail;

  function automatic exp_t model_of(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    logic [31:0] imm;
    e.opcode   = w / (32'd1 << 26);
    e.rs       = (w / (32'd1 << 21)) % 32;
    e.rt       = (w / (32'd1 << 16)) % 32;
    e.rd       = (w / (32'd1 << 11)) % 32;
    e.shamt    = (w / (32'd1 << 6)) % 32;
    e.funct    = w % 64;
    e.is_rtype = (e.opcode == 0) ? 32'd1 : 32'd0;
    imm        = w % 65536;
`ifdef IMM_SIGN_EXT_EN
    if (imm >= 32768) imm = imm - 32'd65536;
`endif
    e.imm_ext    = imm;
    e.branch_off = imm * 4;
    e.jump_addr  = (pc & 32'hF000_0000) + ((w % (32'd1 << 26)) * 4);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit acc;
    bit pop;
    acc = in_valid && m_ready;
    pop = (q.size() > 0) && out_ready;
    if (acc && m_count < MAXC) m_count++;
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(model_of(instr, pc_plus4));
    end
    m_ready = (q.size() != 2);
  endtask

  task automatic compare_all();
    chk("in_ready", 32'(in_ready), 32'(m_ready));
    chk("out_valid", 32'(out_valid), (q.size() > 0) ? 32'd1 : 32'd0);
    chk("instr_count", 32'(instr_count), 32'(m_count));
    if (q.size() > 0) begin
      chk("opcode", 32'(opcode), q[0].opcode);
      chk("rs", 32'(rs), q[0].rs);
      chk("rt", 32'(rt), q[0].rt);
      chk("rd", 32'(rd), q[0].rd);
      chk("shamt", 32'(shamt), q[0].shamt);
      chk("funct", 32'(funct), q[0].funct);
      chk("is_rtype", 32'(is_rtype), q[0].is_rtype);
      chk("imm_ext", imm_ext, q[0].imm_ext);
      chk("branch_off", branch_off, q[0].branch_off);
      chk("jump_addr", jump_addr, q[0].jump_addr);
    end
  endtask

  task automatic cycle(input bit iv, input logic [31:0] w, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    in_valid  = iv;
    instr     = w;
    pc_plus4  = pc;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    @(negedge clk);
    model_step();
    compare_all();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    rst      = 1'b1;
    #1;
    q.delete();
    m_count = 0;
    m_ready = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_imm_ext", imm_ext, 32'd0);
    chk("rst_jump_addr", jump_addr, 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    instr     = '0;
    pc_plus4  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    m_count   = 0;
    m_ready   = 1'b0;

    // Pin the reference model with hand-computed values.
    e = model_of(32'h0022_1820, 32'h4);
    chk("model_rd", e.rd, 32'd3);
    chk("model_funct", e.funct, 32'h20);
    e = model_of(32'h0810_0004, 32'h0040_0004);
    chk("model_jump", e.jump_addr, 32'h0040_0010);

    @(negedge clk);
    do_reset();

    cycle(1'b1, 32'h0022_1820, 32'h0000_0004, 1'b1, 1'b0);
    chk("r_opcode", 32'(opcode), 32'd0);
    chk("r_rs", 32'(rs), 32'd1);
    chk("r_rt", 32'(rt), 32'd2);
    chk("r_rd", 32'(rd), 32'd3);
    chk("r_shamt", 32'(shamt), 32'd0);
    chk("r_funct", 32'(funct), 32'h20);
    chk("r_is_rtype", 32'(is_rtype), 32'd1);

    cycle(1'b1, 32'h0810_0004, 32'h0040_0004, 1'b1, 1'b0);
    chk("j_jump_addr", jump_addr, 32'h0040_0010);
    chk("j_is_rtype", 32'(is_rtype), 32'd0);

    cycle(1'b1, 32'h2008_FFFC, 32'h0000_0008, 1'b1, 1'b0);
`ifdef IMM_SIGN_EXT_EN
    chk("addi_imm_ext", imm_ext, 32'hFFFF_FFFC);
    chk("addi_branch_off", branch_off, 32'hFFFF_FFF0);
`else
    chk("addi_imm_ext", imm_ext, 32'h0000_FFFC);
    chk("addi_branch_off", branch_off, 32'h0003_FFF0);
`endif
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Back-pressure: three offered, two held, third waits.
    cycle(1'b1, 32'h0000_0800, 32'd0, 1'b0, 1'b0);
    chk("bp_a_rd", 32'(rd), 32'd1);
    cycle(1'b1, 32'h0000_1000, 32'd0, 1'b0, 1'b0);
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 32'h0000_1800, 32'd0, 1'b0, 1'b0);
    chk("bp_hold_rd", 32'(rd), 32'd1);
    cycle(1'b1, 32'h0000_1800, 32'd0, 1'b1, 1'b0);
    chk("bp_b_rd", 32'(rd), 32'd2);
    cycle(1'b1, 32'h0000_1800, 32'd0, 1'b1, 1'b0);
    chk("bp_c_rd", 32'(rd), 32'd3);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_count", 32'(instr_count), 32'd6);

    // Flush while full, with an input offered the same cycle.
    cycle(1'b1, 32'h0000_0800, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_1000, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_1800, 32'd0, 1'b0, 1'b1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_count", 32'(instr_count), 32'd8);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("flush_stays_empty", 32'(out_valid), 32'd0);

    // Asynchronous reset while full.
    cycle(1'b1, 32'h0000_0800, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_1000, 32'd0, 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 32'h0022_1820, 32'h0000_0004, 1'b1, 1'b0);
    chk("after_rst_valid", 32'(out_valid), 32'd1);
    chk("after_rst_rd", 32'(rd), 32'd3);
    chk("after_rst_count", 32'(instr_count), 32'd1);

    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
    end
    chk("count_saturated", 32'(instr_count), 32'(MAXC));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
